// File: rtl/alu_cmd_pkg.sv
// Shared opcodes, FSM state encoding and the ALU evaluation function for the
// ALU command responder. Optional result flags: ALU_RSP_FLAGS_EN.
package alu_cmd_pkg;

  localparam int unsigned ALU_W = 2;
  localparam int unsigned RES_W = 2 * ALU_W;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_SHL  = 3'b110;
  localparam logic [2:0] OP_MUL  = 3'b111;

  localparam logic [1:0] ST_EMPTY  = 2'd0;
  localparam logic [1:0] ST_ACTIVE = 2'd1;
  localparam logic [1:0] ST_FULL   = 2'd2;

  typedef struct packed {
    logic             carry;
    logic [RES_W-1:0] y;
  } alu_res_t;

  // Evaluated one bit wider than the result so bit RES_W carries the
  // carry-out (ADD/MUL) or the borrow (SUB).
  function automatic alu_res_t alu_eval(input logic [ALU_W-1:0] a,
                                        input logic [ALU_W-1:0] b,
                                        input logic             cin,
                                        input logic [2:0]       sel);
    logic [RES_W:0] ea;
    logic [RES_W:0] eb;
    logic [RES_W:0] ec;
    logic [RES_W:0] wide;
    alu_res_t       r;
    ea = '0;
    eb = '0;
    ec = '0;
    ea[ALU_W-1:0] = a;
    eb[ALU_W-1:0] = b;
    ec[0]         = cin;
    wide          = '0;
    case (sel)
      OP_ADD:  wide = ea + eb + ec;
      OP_SUB:  wide = ea - eb - ec;
      OP_AND:  wide = ea & eb;
      OP_OR:   wide = ea | eb;
      OP_XOR:  wide = ea ^ eb;
      OP_NOTA: wide[ALU_W-1:0] = ~a;
      OP_SHL:  wide = ea << b;
      default: wide = ea * eb;
    endcase
    r.y     = wide[RES_W-1:0];
    r.carry = ((sel == OP_ADD) || (sel == OP_SUB) || (sel == OP_MUL)) ? wide[RES_W] : 1'b0;
    return r;
  endfunction

endpackage

// File: rtl/alu_cmd_responder_if.sv
// Command/response bus of the ALU command responder. With ALU_RSP_FLAGS_EN
// defined the response also carries rsp_carry and rsp_zero.
interface alu_cmd_responder_if #(
  parameter int unsigned W     = 2,
  parameter int unsigned CNT_W = 16
);
  // Both channels are valid/ready: a transfer happens on a rising edge where
  // valid && ready; the sender holds its payload stable while valid && !ready,
  // and ready never depends combinationally on valid.
  logic             cmd_valid;
  logic             cmd_ready;
  logic [W-1:0]     cmd_a;
  logic [W-1:0]     cmd_b;
  logic             cmd_cin;
  logic [2:0]       cmd_sel;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*W-1:0]   rsp_y;
  logic [CNT_W-1:0] op_count;
`ifdef ALU_RSP_FLAGS_EN
  logic             rsp_carry;
  logic             rsp_zero;

  modport master (output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_sel, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_y, op_count, rsp_carry, rsp_zero);
  modport slave  (input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_sel, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_y, op_count, rsp_carry, rsp_zero);
`else
  modport master (output cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_sel, rsp_ready,
                  input  cmd_ready, rsp_valid, rsp_y, op_count);
  modport slave  (input  cmd_valid, cmd_a, cmd_b, cmd_cin, cmd_sel, rsp_ready,
                  output cmd_ready, rsp_valid, rsp_y, op_count);
`endif
endinterface

// File: rtl/alu_rsp_fifo.sv
// Generic synchronous FIFO with occupancy count; push at full is accepted
// when a pop happens in the same cycle. Read data is zero while empty.
module alu_rsp_fifo #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int unsigned AW     = $clog2(DEPTH);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_MAX);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/alu_cmd_responder.sv
// Handshaked ALU command responder: register stage, ALU evaluation, response
// FIFO and saturating pop counter. Optional flags via ALU_RSP_FLAGS_EN.
module alu_cmd_responder
  import alu_cmd_pkg::*;
#(
  parameter int unsigned W     = ALU_W,  // alu_eval is sized by ALU_W; keep them equal
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_responder_if.slave  bus,
  output logic [1:0]          dbg_state
);
  localparam int unsigned AW = $clog2(DEPTH);
`ifdef ALU_RSP_FLAGS_EN
  localparam int unsigned FW = 2*W + 2;
`else
  localparam int unsigned FW = 2*W;
`endif
  localparam logic [AW+1:0] CREDIT_MAX = (AW+2)'(DEPTH);

  logic             ready_en;
  logic             stage_valid;
  logic [W-1:0]     stage_a;
  logic [W-1:0]     stage_b;
  logic             stage_cin;
  logic [2:0]       stage_sel;
  logic             accept;
  logic             pop_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [AW:0]      fifo_count;
  logic [AW+1:0]    credit_used;
  logic [FW-1:0]    fifo_wdata;
  logic [FW-1:0]    fifo_rdata;
  logic [CNT_W-1:0] op_cnt_q;
  alu_res_t         res;

  // Credit covers the stage register too, so a staged result always has a
  // free FIFO slot and ready depends on registered state only.
  assign credit_used   = {1'b0, fifo_count} + {{(AW+1){1'b0}}, stage_valid};
  assign bus.cmd_ready = ready_en && (credit_used < CREDIT_MAX);
  assign accept        = bus.cmd_valid && bus.cmd_ready;
  assign pop_fire      = bus.rsp_valid && bus.rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_valid <= 1'b0;
      stage_a     <= '0;
      stage_b     <= '0;
      stage_cin   <= 1'b0;
      stage_sel   <= '0;
    end else begin
      stage_valid <= accept;
      if (accept) begin
        stage_a   <= bus.cmd_a;
        stage_b   <= bus.cmd_b;
        stage_cin <= bus.cmd_cin;
        stage_sel <= bus.cmd_sel;
      end
    end
  end

  assign res = alu_eval(stage_a, stage_b, stage_cin, stage_sel);

`ifdef ALU_RSP_FLAGS_EN
  assign fifo_wdata = {res.carry, (res.y == '0), res.y};
`else
  assign fifo_wdata = res.y;
`endif

  alu_rsp_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (stage_valid),
    .wdata (fifo_wdata),
    .pop   (bus.rsp_ready),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.rsp_valid = !fifo_empty;
  assign bus.rsp_y     = fifo_rdata[2*W-1:0];
`ifdef ALU_RSP_FLAGS_EN
  assign bus.rsp_zero  = fifo_rdata[2*W];
  assign bus.rsp_carry = fifo_rdata[2*W+1];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         op_cnt_q <= '0;
    else if (pop_fire && !(&op_cnt_q))  op_cnt_q <= op_cnt_q + CNT_W'(1);
  end
  assign bus.op_count = op_cnt_q;

  always_comb begin
    dbg_state = ST_ACTIVE;
    if ((fifo_count == '0) && !stage_valid)       dbg_state = ST_EMPTY;
    else if (fifo_full || (credit_used == CREDIT_MAX)) dbg_state = ST_FULL;
  end
endmodule

// File: tb/tb_alu_cmd_responder.sv
// Directed self-checking bench for alu_cmd_responder; flag checks are active
// when ALU_RSP_FLAGS_EN is defined.
module tb_alu_cmd_responder;
  import alu_cmd_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         total  = 0;
  int         passed = 0;
  int         acc    = 0;

  int         sweep_exp [8] = '{6, 0, 3, 3, 0, 0, 8, 9};
  logic [1:0] bp_a   [6] = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd3, 2'd0};
  logic [1:0] bp_b   [6] = '{2'd1, 2'd3, 2'd2, 2'd1, 2'd3, 2'd0};
  logic [2:0] bp_sel [6] = '{OP_ADD, OP_MUL, OP_SHL, OP_SUB, OP_ADD, OP_OR};
  int         drain_exp [4] = '{6, 12, 1, 6};

  alu_cmd_responder_if #(.W(2), .CNT_W(16)) bus ();

  alu_cmd_responder #(.W(2), .DEPTH(4), .CNT_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic drive_cmd(input logic [1:0] a, input logic [1:0] b,
                           input logic cin, input logic [2:0] sel);
    bus.cmd_valid = 1'b1;
    bus.cmd_a     = a;
    bus.cmd_b     = b;
    bus.cmd_cin   = cin;
    bus.cmd_sel   = sel;
  endtask

  // One command from idle with rsp_ready=1: accept, stage, head, pop.
  task automatic send_one(input string tag, input logic [1:0] a, input logic [1:0] b,
                          input logic cin, input logic [2:0] sel,
                          input int exp_y, input logic exp_c);
    drive_cmd(a, b, cin, sel);
    check({tag, "_ready"}, bus.cmd_ready, 1);
    tick();
    bus.cmd_valid = 1'b0;
    check({tag, "_lat1"}, bus.rsp_valid, 0);
    tick();
    check({tag, "_valid"}, bus.rsp_valid, 1);
    check({tag, "_y"}, bus.rsp_y, exp_y);
`ifdef ALU_RSP_FLAGS_EN
    check({tag, "_carry"}, bus.rsp_carry, exp_c);
    check({tag, "_zero"}, bus.rsp_zero, (exp_y == 0));
`else
    if (exp_c === 1'bx) check({tag, "_carry_arg"}, exp_c, 0);
`endif
    tick();
    check({tag, "_popped"}, bus.rsp_valid, 0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_a     = '0;
    bus.cmd_b     = '0;
    bus.cmd_cin   = 1'b0;
    bus.cmd_sel   = '0;
    bus.rsp_ready = 1'b0;
    tick();
    tick();
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    check("rst_op_count", bus.op_count, 0);
    check("rst_state", dbg_state, ST_EMPTY);
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_ready", bus.cmd_ready, 1);

    // Opcode sweep A=3 B=3 Cin=0, back-to-back with the consumer always ready.
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive_cmd(2'd3, 2'd3, 1'b0, 3'(i));
      check("sweep_ready", bus.cmd_ready, 1);
      tick();
      if (i == 0) begin
        check("sweep_lat1", bus.rsp_valid, 0);
      end else begin
        check("sweep_valid", bus.rsp_valid, 1);
        check("sweep_y", bus.rsp_y, sweep_exp[i-1]);
`ifdef ALU_RSP_FLAGS_EN
        check("sweep_zero", bus.rsp_zero, (sweep_exp[i-1] == 0));
`endif
      end
    end
    bus.cmd_valid = 1'b0;
    tick();
    check("sweep_last_y", bus.rsp_y, sweep_exp[7]);
    tick();
    check("sweep_drained", bus.rsp_valid, 0);
    check("sweep_op_count", bus.op_count, 8);

    // Carry/borrow in.
    send_one("add_cin", 2'd3, 2'd3, 1'b1, OP_ADD, 7, 1'b0);
    send_one("sub_cin", 2'd3, 2'd3, 1'b1, OP_SUB, 15, 1'b1);
    check("cin_op_count", bus.op_count, 10);

    // Backpressure: offer six commands with the consumer stalled.
    bus.rsp_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 8; c++) begin
      if (acc < 6) drive_cmd(bp_a[acc], bp_b[acc], 1'b0, bp_sel[acc]);
      else         bus.cmd_valid = 1'b0;
      if (bus.cmd_ready && bus.cmd_valid) acc++;
      tick();
    end
    check("bp_accepted", acc, 4);
    check("bp_ready_low", bus.cmd_ready, 0);
    check("bp_valid", bus.rsp_valid, 1);
    check("bp_head_y", bus.rsp_y, 2);
    check("bp_state_full", dbg_state, ST_FULL);

    // One-cycle pop at full while a command waits: pop first, credit next.
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("pulse_op_count", bus.op_count, 11);
    check("pulse_head_y", bus.rsp_y, 6);
    check("pulse_credit", bus.cmd_ready, 1);
    check("pulse_state", dbg_state, ST_ACTIVE);
    tick();
    bus.cmd_valid = 1'b0;
    check("refill_ready_low", bus.cmd_ready, 0);
    tick();
    check("refill_state_full", dbg_state, ST_FULL);
    check("refill_head_hold", bus.rsp_y, 6);

    bus.rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("drain_valid", bus.rsp_valid, 1);
      check("drain_y", bus.rsp_y, drain_exp[k]);
      tick();
    end
    check("drain_empty", bus.rsp_valid, 0);
    check("drain_ready", bus.cmd_ready, 1);
    check("drain_op_count", bus.op_count, 15);
    check("drain_state", dbg_state, ST_EMPTY);

    // Reset with three entries queued.
    bus.rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive_cmd(2'(k), 2'd1, 1'b0, OP_ADD);
      tick();
    end
    bus.cmd_valid = 1'b0;
    tick();
    tick();
    check("mid_queued_valid", bus.rsp_valid, 1);
    check("mid_queued_y", bus.rsp_y, 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", bus.rsp_valid, 0);
    check("mid_rst_op_count", bus.op_count, 0);
    check("mid_rst_y", bus.rsp_y, 0);
    check("mid_rst_ready", bus.cmd_ready, 0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    tick();
    check("mid_release_ready", bus.cmd_ready, 1);
    check("mid_release_empty", bus.rsp_valid, 0);
    bus.rsp_ready = 1'b1;
    send_one("post_rst_add", 2'd1, 2'd2, 1'b0, OP_ADD, 3, 1'b0);
    check("post_rst_op_count", bus.op_count, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
